pipe_skid_stage: RTL and testbench

- Parametrised pipeline stage register for inter-stage boundaries (fetch/decode and later stages).
- Replaces hold-by-recirculation stalling with a valid/ready handshake backed by a 2-entry skid buffer. `in_ready` is therefore a registered signal and never combinationally depends on `out_ready`.
- Adds flush (bubble insertion), a configurable NOP payload for empty slots, and saturating stall/flush performance counters.

---
 rtl/pipe_skid_stage.sv | 113 +++++++++++
 tb/tb_pipe_skid_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a registered-ready valid/ready handshake and a 2-entry skid buffer.
// Adds flush (bubble insertion), NOP payload on empty output, and saturating stall/flush counters.
module pipe_skid_stage #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16,
    parameter int FW_W    = 5,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               in_err,
    input  logic [FW_W-1:0]    in_fwA,
    input  logic [FW_W-1:0]    in_fwB,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_err,
    output logic [FW_W-1:0]    out_fwA,
    output logic [FW_W-1:0]    out_fwB,
    input  logic               flush,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic [1:0]         dbg_state
);

    localparam int PW = INSTR_W + PC_W + 1 + 2 * FW_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Handshake: an entry moves upstream->stage when in_valid & in_ready on a rising
    // edge, and stage->downstream when out_valid & out_ready. in_ready is a register.
    state_t          state;
    logic [PW-1:0]   m_q;
    logic [PW-1:0]   s_q;
    logic [PW-1:0]   in_payload;
    logic            accept;
    logic            consume;

    assign in_payload = {in_instr, in_pc, in_err, in_fwA, in_fwB};
    assign out_valid  = (state != EMPTY);
    assign accept     = in_valid & in_ready;
    assign consume    = out_valid & out_ready;
    assign dbg_state  = state;

    // Masking at the output means stale M contents can never leak after a flush.
    assign {out_instr, out_pc, out_err, out_fwA, out_fwB} =
        out_valid ? m_q : {NOP_INSTR, {(PW-INSTR_W){1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            m_q       <= '0;
            s_q       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_ONE;

            if (flush) begin
                state    <= EMPTY;
                in_ready <= 1'b1;
                if (state != EMPTY && flush_cnt != CNT_MAX)
                    flush_cnt <= flush_cnt + CNT_ONE;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            m_q   <= in_payload;
                            state <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && consume) begin
                            m_q <= in_payload;
                        end else if (accept) begin
                            s_q      <= in_payload;
                            state    <= TWO;
                            in_ready <= 1'b0;
                        end else if (consume) begin
                            state <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (consume) begin
                            m_q      <= s_q;
                            state    <= ONE;
                            in_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= EMPTY;
                        in_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, counter saturation sequence on a
// 4-bit-counter instance, then random traffic against a queue-based reference model.
module tb_pipe_skid_stage;

    localparam int PW = 43;
    localparam logic [PW-1:0] NOP_P = {16'h0800, 27'd0};

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        in_err;
    logic [4:0]  in_fwA;
    logic [4:0]  in_fwB;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        out_err;
    logic [4:0]  out_fwA;
    logic [4:0]  out_fwB;
    logic        flush;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [1:0]  dbg_state;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_out_instr;
    logic [15:0] s_out_pc;
    logic        s_out_err;
    logic [4:0]  s_out_fwA;
    logic [4:0]  s_out_fwB;
    logic [3:0]  s_stall_cnt;
    logic [3:0]  s_flush_cnt;
    logic [1:0]  s_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_skid_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_err(in_err), .in_fwA(in_fwA), .in_fwB(in_fwB),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_err(out_err), .out_fwA(out_fwA), .out_fwB(out_fwB), .flush(flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
    );

    pipe_skid_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_err(in_err), .in_fwA(in_fwA), .in_fwB(in_fwB),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr), .out_pc(s_out_pc),
        .out_err(s_out_err), .out_fwA(s_out_fwA), .out_fwB(s_out_fwB), .flush(flush),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .dbg_state(s_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        iv;
        logic [15:0] instr;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [15:0] oinstr;
        logic        ir;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    vec_t tbl[21];

    // Payload fields are derived from the instruction so one value identifies a whole entry.
    function automatic logic [PW-1:0] pack(input logic [15:0] instr);
        logic [15:0] pc;
        pc = instr + 16'd4;
        return {instr, pc, instr[0], instr[4:0], instr[9:5]};
    endfunction

    function automatic vec_t mk(input logic r, iv, input logic [15:0] instr, input logic ordy, fl,
                                input logic ov, input logic [15:0] oinstr, input logic ir,
                                input logic [15:0] sc, fc);
        vec_t v;
        v.r = r; v.iv = iv; v.instr = instr; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.oinstr = oinstr; v.ir = ir; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    // driver tasks
    task automatic drive(input logic r, iv, input logic [15:0] instr, input logic ordy, fl);
        rst       = r;
        in_valid  = iv;
        {in_instr, in_pc, in_err, in_fwA, in_fwB} = pack(instr);
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard / reference model: the stage is a FIFO of capacity two
    logic [PW-1:0] exp_q[$];
    int m_sc, m_fc, m_ss;

    task automatic model_step(input logic r, iv, input logic [15:0] instr, input logic ordy, fl,
                              output logic accepted);
        accepted = 1'b0;
        if (r) begin
            exp_q.delete();
            m_sc = 0; m_fc = 0; m_ss = 0;
        end else begin
            if (exp_q.size() > 0 && !ordy) begin
                if (m_sc < 65535) m_sc++;
                if (m_ss < 15) m_ss++;
            end
            if (fl) begin
                if (exp_q.size() > 0 && m_fc < 65535) m_fc++;
                exp_q.delete();
            end else begin
                accepted = iv && (exp_q.size() < 2);
                if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
                if (accepted) exp_q.push_back(pack(instr));
            end
        end
    endtask

    initial begin
        logic [PW-1:0] exp_p;
        logic [1:0]    exp_st;
        logic          pend;
        logic [15:0]   pend_instr;
        logic          r, ordy, fl, acc;

        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        //          r  iv  instr     ordy fl   ov  oinstr    ir  sc  fc
        tbl[0]  = mk(1, 0, 16'h0000, 0,   0,   0, 16'h0800, 1,  0,  0);
        tbl[1]  = mk(0, 1, 16'h1111, 1,   0,   1, 16'h1111, 1,  0,  0);
        tbl[2]  = mk(0, 1, 16'h2222, 1,   0,   1, 16'h2222, 1,  0,  0);
        tbl[3]  = mk(0, 1, 16'h3333, 1,   0,   1, 16'h3333, 1,  0,  0);
        tbl[4]  = mk(0, 0, 16'h0000, 1,   0,   0, 16'h0800, 1,  0,  0);
        tbl[5]  = mk(0, 1, 16'hA001, 0,   0,   1, 16'hA001, 1,  0,  0);
        tbl[6]  = mk(0, 1, 16'hA002, 0,   0,   1, 16'hA001, 0,  1,  0);
        tbl[7]  = mk(0, 1, 16'hA003, 0,   0,   1, 16'hA001, 0,  2,  0);
        tbl[8]  = mk(0, 1, 16'hA003, 1,   0,   1, 16'hA002, 1,  2,  0);
        tbl[9]  = mk(0, 1, 16'hA003, 1,   0,   1, 16'hA003, 1,  2,  0);
        tbl[10] = mk(0, 0, 16'h0000, 1,   0,   0, 16'h0800, 1,  2,  0);
        tbl[11] = mk(0, 1, 16'hB001, 0,   0,   1, 16'hB001, 1,  2,  0);
        tbl[12] = mk(0, 1, 16'hB002, 0,   0,   1, 16'hB001, 0,  3,  0);
        tbl[13] = mk(0, 0, 16'h0000, 1,   1,   0, 16'h0800, 1,  3,  1);
        tbl[14] = mk(0, 0, 16'h0000, 1,   1,   0, 16'h0800, 1,  3,  1);
        tbl[15] = mk(0, 1, 16'hBEEF, 1,   1,   0, 16'h0800, 1,  3,  1);
        tbl[16] = mk(0, 0, 16'h0000, 1,   0,   0, 16'h0800, 1,  3,  1);
        tbl[17] = mk(0, 1, 16'hC001, 0,   0,   1, 16'hC001, 1,  3,  1);
        tbl[18] = mk(0, 1, 16'hC002, 0,   0,   1, 16'hC001, 0,  4,  1);
        tbl[19] = mk(1, 1, 16'hC003, 0,   1,   0, 16'h0800, 1,  0,  0);
        tbl[20] = mk(0, 0, 16'h0000, 0,   0,   0, 16'h0800, 1,  0,  0);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].r, tbl[i].iv, tbl[i].instr, tbl[i].ordy, tbl[i].fl);
            @(posedge clk);
            #1;
            exp_p  = tbl[i].ov ? pack(tbl[i].oinstr) : NOP_P;
            exp_st = !tbl[i].ov ? 2'd0 : (!tbl[i].ir ? 2'd2 : 2'd1);
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
            check($sformatf("vec%0d payload", i),
                  64'({out_instr, out_pc, out_err, out_fwA, out_fwB}), 64'(exp_p));
            check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
            check($sformatf("vec%0d state", i), 64'(dbg_state), 64'(exp_st));
            check($sformatf("vec%0d stall_cnt", i), 64'(stall_cnt), 64'(tbl[i].sc));
            check($sformatf("vec%0d flush_cnt", i), 64'(flush_cnt), 64'(tbl[i].fc));
        end

        // Counter saturation: one held entry, downstream stalled for 20 cycles.
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 16'hD001, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("sat first stall", 64'(s_stall_cnt), 64'd0);
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
            @(posedge clk); #1;
            check($sformatf("sat small stall_cnt k=%0d", k), 64'(s_stall_cnt), 64'((k < 15) ? k : 15));
            check($sformatf("sat wide stall_cnt k=%0d", k), 64'(stall_cnt), 64'(k));
        end
        check("sat held entry", 64'(s_out_instr), 64'h0000_0000_0000_D001);

        // Random traffic against the reference model.
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        model_step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, acc);
        @(posedge clk); #1;
        pend = 1'b0;
        pend_instr = 16'h0;
        for (int c = 0; c < 1500; c++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pend_instr = 16'($urandom);
            end
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 15) == 0);
            r    = ($urandom_range(0, 199) == 0);
            drive(r, pend, pend_instr, ordy, fl);
            model_step(r, pend, pend_instr, ordy, fl, acc);
            if (acc) pend = 1'b0;
            @(posedge clk); #1;
            exp_p = (exp_q.size() > 0) ? exp_q[0] : NOP_P;
            check($sformatf("rand%0d out_valid", c), 64'(out_valid), 64'(exp_q.size() > 0));
            check($sformatf("rand%0d payload", c),
                  64'({out_instr, out_pc, out_err, out_fwA, out_fwB}), 64'(exp_p));
            check($sformatf("rand%0d in_ready", c), 64'(in_ready), 64'(exp_q.size() < 2));
            check($sformatf("rand%0d stall_cnt", c), 64'(stall_cnt), 64'(m_sc));
            check($sformatf("rand%0d flush_cnt", c), 64'(flush_cnt), 64'(m_fc));
            check($sformatf("rand%0d small stall_cnt", c), 64'(s_stall_cnt), 64'(m_ss));
            check($sformatf("rand%0d small out_valid", c), 64'(s_out_valid), 64'(exp_q.size() > 0));
        end

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
